monsopc_sysid_checker: RTL

Boot-time system-identity checker sitting directly downstream of the system ID peripheral on its Avalon-MM control slave. On a start request (or automatically after reset) it reads the ID word (address 0) and the timestamp word (address 1), compares both against expected build constants, and reports a registered pass/fail verdict with a per-read timeout. Its verdict gates software boot in the SOPC system and drives a status LED.

---
 rtl/monsopc_sysid_pkg.sv | 19 +
 rtl/monsopc_sysid_checker.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/monsopc_sysid_pkg.sv
// Shared definitions for the boot-time system-identity checker.
package monsopc_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Word addresses inside the system ID slave.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Build constants the identity words are normally checked against.
  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1604668952;

endpackage

// File: rtl/monsopc_sysid_checker.sv
// Reads the ID and timestamp words from the system ID peripheral, compares
// them with the expected build constants and registers a pass/fail verdict.
// Each read is abandoned if the slave stalls it for TIMEOUT_CYCLES cycles.
module monsopc_sysid_checker
  import monsopc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen during the last stalled cycle before the read is dropped.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             auto_pend_q, auto_pend_d;
  logic [31:0]      id_value_q, id_value_d;
  logic [31:0]      ts_value_q, ts_value_d;
  logic             id_ok_q, id_ok_d;
  logic             ts_ok_q, ts_ok_d;
  logic             timeout_q, timeout_d;

  // State register and verdict registers; reset re-arms the auto-start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      auto_pend_q <= AUTO_START;
      id_value_q  <= '0;
      ts_value_q  <= '0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      auto_pend_q <= auto_pend_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic: sequence the two reads, count stalls, update the verdict.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    auto_pend_d = auto_pend_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (start || auto_pend_q) begin
          auto_pend_d = 1'b0;
          state_d     = RD_ID;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          wait_cnt_d = '0;
          state_d    = RD_TS;
        end else if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          state_d    = REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          id_ok_d    = (id_value_q == EXPECTED_ID);
          ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
          timeout_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = REPORT;
        end else if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          state_d    = REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decode straight from the state, so address and
  // read strobe cannot move while the slave is stalling.
  always_comb begin
    busy        = (state_q == RD_ID) || (state_q == RD_TS);
    avm_read    = busy;
    avm_address = (state_q == RD_TS) ? ADDR_TS : ADDR_ID;
    done        = (state_q == REPORT);
    id_ok       = id_ok_q;
    ts_ok       = ts_ok_q;
    timeout     = timeout_q;
    id_value    = id_value_q;
    ts_value    = ts_value_q;
  end

endmodule
